// File: rtl/gate_tt_sequencer_if.sv
// Bus between the truth-table sweep controller and its environment.
// The controller attaches through the slave modport, and the environment
// uses the master modport. The environment drives start, the expected
// truth table and the gate output. It observes the stimulus and the
// sweep results.
interface gate_tt_sequencer_if #(
  parameter int N_IN = 2
) ();

  logic                    start;
  logic [(2**N_IN)-1:0]    exp_tt;
  logic                    dut_y;
  logic [N_IN-1:0]         dut_in;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [N_IN:0]           err_cnt;
  logic [(2**N_IN)-1:0]    fail_vec;

  modport slave (
    input  start,
    input  exp_tt,
    input  dut_y,
    output dut_in,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output fail_vec
  );

  modport master (
    output start,
    output exp_tt,
    output dut_y,
    input  dut_in,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  fail_vec
  );

endinterface

// File: rtl/gate_tt_sequencer.sv
// Truth-table sweep controller for one N_IN-input basic gate.
// - On start, the controller drives every input combination onto the
//   external gate in ascending order.
// - It samples the gate output SETTLE cycles after each vector is applied.
// - It compares each sample against a latched copy of the expected table.
// Optional feature macro: STOP_ON_FAIL_EN. When defined, the sweep ends
// at the first mismatching vector.
module gate_tt_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_tt_sequencer_if.slave   bus
);

  localparam int NVEC   = 2**N_IN;
  localparam int CW     = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam bit HAS_WAIT = (SETTLE > 0);
  localparam logic [CW-1:0]   CNT_LOAD = CW'((SETTLE > 0) ? (SETTLE - 1) : 0);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NVEC-1:0]   exp_q, exp_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic [N_IN:0]     err_q, err_d;
  logic [NVEC-1:0]   fail_q, fail_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mismatch_s;

  // The sampled gate output disagrees with the latched expectation for the current vector.
  assign mismatch_s = bus.dut_y ^ exp_q[idx_q];

  // Next-state and datapath decode for the sweep FSM.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    dut_in_d = dut_in_q;
    err_d    = err_q;
    fail_d   = fail_q;
    pass_d   = pass_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Results are cleared only when a new sweep is accepted, so they
          // persist for inspection between sweeps.
          state_d  = S_APPLY;
          exp_d    = bus.exp_tt;
          err_d    = '0;
          fail_d   = '0;
          pass_d   = 1'b0;
          idx_d    = '0;
          dut_in_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_APPLY: begin
        // The vector is already driven (loaded on entry to APPLY).
        if (HAS_WAIT) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = S_SAMPLE;
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end

      S_SAMPLE: begin
        if (mismatch_s) begin
          err_d         = err_q + {{N_IN{1'b0}}, 1'b1};
          fail_d[idx_q] = 1'b1;
        end else begin
          err_d = err_q;
        end
`ifdef STOP_ON_FAIL_EN
        if (mismatch_s || (idx_q == IDX_LAST)) begin
`else
        if (idx_q == IDX_LAST) begin
`endif
          // Verdict is captured together with the done pulse.
          state_d = S_DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d  = S_APPLY;
          idx_d    = idx_q + {{(N_IN-1){1'b0}}, 1'b1};
          dut_in_d = idx_q + {{(N_IN-1){1'b0}}, 1'b1};
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered versions of the next state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      dut_in_q <= '0;
      err_q    <= '0;
      fail_q   <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      dut_in_q <= dut_in_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.dut_in   = dut_in_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Self-checking bench for gate_tt_sequencer.
// - A 2-input instance is driven from a table of gate models and expected
//   truth tables.
// - Hand-written sequences cover start re-pulses while busy, a reset in the
//   middle of a sweep, and a 3-input instance with no wait state.
module tb_gate_tt_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_tt_sequencer_if #(.N_IN(2)) bus ();
  gate_tt_sequencer_if #(.N_IN(3)) bus3 ();

  gate_tt_sequencer #(.N_IN(2), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  gate_tt_sequencer #(.N_IN(3), .SETTLE(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
  );

  // Behavioural gate models: 0 NOR, 1 AND, 2 OR, 3 XOR.
  logic [1:0] gsel;
  always_comb begin
    case (gsel)
      2'd0:    bus.dut_y = ~(|bus.dut_in);
      2'd1:    bus.dut_y = &bus.dut_in;
      2'd2:    bus.dut_y = |bus.dut_in;
      default: bus.dut_y = ^bus.dut_in;
    endcase
  end
  always_comb bus3.dut_y = ~(|bus3.dut_in);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] gsel;
    logic [3:0] exp_tt;
    int         err;
    logic [3:0] fv;
    int         pass;
    int         dcyc;
    int         last;
  } vec_t;

  vec_t tbl [5];

  // Pulse start for one edge; returns just after the start edge.
  task automatic kick();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Watch one sweep cycle by cycle (cycle 1 = first cycle after the start edge).
  // mode 1 re-pulses start at cycles 5 and 9 and flips exp_tt at cycle 6.
  task automatic watch(input int mode, output int dcyc, output int seqerr, output int busyerr);
    dcyc = 0; seqerr = 0; busyerr = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mode == 1) begin
        bus.start = (k == 5 || k == 9);
        if (k == 6) bus.exp_tt = 4'b1110;
      end
      if (!bus.busy) busyerr++;
      if (bus.done) begin
        dcyc = k;
        break;
      end
      if (bus.dut_in !== 2'((k - 1) / 3)) seqerr++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int dcyc, seqerr, busyerr;
    bus.start = 1'b0; bus.exp_tt = 4'b0001; gsel = 2'd0;
    bus3.start = 1'b0; bus3.exp_tt = 8'h01;

    tbl[0] = '{"nor_ok",  2'd0, 4'b0001, 0, 4'b0000, 1, 13, 3};
    tbl[2] = '{"or_ok",   2'd2, 4'b1110, 0, 4'b0000, 1, 13, 3};
    tbl[3] = '{"xor_vs_or", 2'd3, 4'b1110, 1, 4'b1000, 0, 13, 3};
`ifdef STOP_ON_FAIL_EN
    tbl[1] = '{"and_vs_nor", 2'd1, 4'b0001, 1, 4'b0001, 0, 4, 0};
    tbl[4] = '{"and_vs_nand", 2'd1, 4'b0111, 1, 4'b0001, 0, 4, 0};
`else
    tbl[1] = '{"and_vs_nor", 2'd1, 4'b0001, 2, 4'b1001, 0, 13, 3};
    tbl[4] = '{"and_vs_nand", 2'd1, 4'b0111, 4, 4'b1111, 0, 13, 3};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_err", bus.err_cnt, 0);
    chk("rst_fv", bus.fail_vec, 0);
    chk("rst_dut_in", bus.dut_in, 0);
    chk("rst3_dut_in", bus3.dut_in, 0);
    rst_n = 1'b1;

    // Table-driven sweeps
    foreach (tbl[i]) begin
      gsel = tbl[i].gsel;
      bus.exp_tt = tbl[i].exp_tt;
      kick();
      watch(0, dcyc, seqerr, busyerr);
      chk({tbl[i].name, "_done_cyc"}, dcyc, tbl[i].dcyc);
      chk({tbl[i].name, "_seq"}, seqerr, 0);
      chk({tbl[i].name, "_busy"}, busyerr, 0);
      chk({tbl[i].name, "_err"}, bus.err_cnt, tbl[i].err);
      chk({tbl[i].name, "_fv"}, bus.fail_vec, tbl[i].fv);
      chk({tbl[i].name, "_pass"}, bus.pass, tbl[i].pass);
      chk({tbl[i].name, "_last_in"}, bus.dut_in, tbl[i].last);
      @(negedge clk);
      chk({tbl[i].name, "_done_1cyc"}, bus.done, 0);
      chk({tbl[i].name, "_idle"}, bus.busy, 0);
      repeat (3) @(negedge clk);
      chk({tbl[i].name, "_hold_err"}, bus.err_cnt, tbl[i].err);
      chk({tbl[i].name, "_hold_fv"}, bus.fail_vec, tbl[i].fv);
      chk({tbl[i].name, "_hold_pass"}, bus.pass, tbl[i].pass);
      chk({tbl[i].name, "_hold_in"}, bus.dut_in, tbl[i].last);
    end

    // Start re-pulsed while busy and exp_tt changed mid-sweep: single sweep
    gsel = 2'd0; bus.exp_tt = 4'b0001;
    kick();
    watch(1, dcyc, seqerr, busyerr);
    chk("repulse_done_cyc", dcyc, 13);
    chk("repulse_pass", bus.pass, 1);
    chk("repulse_err", bus.err_cnt, 0);
    begin
      int extra_done = 0;
      int extra_busy = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (bus.done) extra_done++;
        if (bus.busy) extra_busy++;
      end
      chk("repulse_no_2nd_done", extra_done, 0);
      chk("repulse_no_restart", extra_busy, 0);
    end
    bus.exp_tt = 4'b0001;

    // Reset in the middle of a failing sweep (AND against NOR table)
    gsel = 2'd1;
    kick();
    begin
      int early_done = 0;
      for (int k = 1; k <= 7; k++) begin
        @(negedge clk);
        if (bus.done) early_done++;
        if (k == 7) rst_n = 1'b0;
      end
      @(negedge clk);
      chk("midrst_no_done", early_done + int'(bus.done), 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_pass", bus.pass, 0);
      chk("midrst_dut_in", bus.dut_in, 0);
      chk("midrst_err", bus.err_cnt, 0);
      chk("midrst_fv", bus.fail_vec, 0);
      // Start asserted on the very first edge with rst_n high.
      gsel = 2'd0;
      rst_n = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      watch(0, dcyc, seqerr, busyerr);
      chk("postrst_done_cyc", dcyc, 13);
      chk("postrst_pass", bus.pass, 1);
      chk("postrst_seq", seqerr, 0);
    end

    // 3-input NOR, SETTLE=0: each vector held 2 cycles, done at cycle 17
    begin
      int d3 = 0;
      int s3 = 0;
      @(posedge clk);
      #1 bus3.start = 1'b1;
      @(posedge clk);
      #1 bus3.start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (bus3.done) begin
          d3 = k;
          break;
        end
        if (bus3.dut_in !== 3'((k - 1) / 2)) s3++;
      end
      chk("n3_done_cyc", d3, 17);
      chk("n3_seq", s3, 0);
      chk("n3_pass", bus3.pass, 1);
      chk("n3_err", bus3.err_cnt, 0);
      chk("n3_last_in", bus3.dut_in, 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
